// File: rtl/addatone_spi_pkg.sv
// Shared definitions for the ADC control-link SPI master and its receiver.
package addatone_spi_pkg;

  localparam int ADC_WORD_BITS = 16;
  localparam int ADC_NUM_WORDS = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Width that holds 0..max_val-1; never narrower than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/spi_phase_timer.sv
// Loadable down-counter; o_tc is high once the count has reached zero.
// Loading N-1 gives a phase that lasts exactly N cycles.
module spi_phase_timer #(
  parameter int W = 2
) (
  input  logic         i_Clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/adc_spi_master.sv
// SPI master for the ADC control link: CS-framed, SCK idle low, MSB first,
// MOSI only changes while SCK is low so it is stable at every SCK rise.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | CS high, waiting for i_Start
// ST_SETUP | CS low, SCK low, first bit on MOSI, CS_SETUP cycles
// ST_HIGH  | SCK high for CLK_DIV cycles (receiver samples here)
// ST_LOW   | SCK low for CLK_DIV cycles, next bit presented on entry
// ST_HOLD  | SCK low after the last bit, MOSI held, CLK_DIV cycles
// ST_GAP   | CS high, still busy, CS_IDLE cycles before Done
module adc_spi_master
  import addatone_spi_pkg::*;
#(
  parameter int CLK_DIV   = 4,
  parameter int WORD_BITS = ADC_WORD_BITS,
  parameter int NUM_WORDS = ADC_NUM_WORDS,
  parameter int CS_SETUP  = 2,
  parameter int CS_IDLE   = 4
) (
  input  logic                           i_Clock,
  input  logic                           reset,
  input  logic                           i_Start,
  input  logic [WORD_BITS*NUM_WORDS-1:0] i_Data,
  output logic                           o_Busy,
  output logic                           o_Done,
  output logic                           o_ADC_Data,
  output logic                           o_ADC_Clock,
  output logic                           o_ADC_CS
);

  localparam int TOTAL_BITS = WORD_BITS * NUM_WORDS;
  localparam int BIT_W      = (TOTAL_BITS > 1) ? $clog2(TOTAL_BITS) : 1;
  localparam int TMR_W      = cnt_width(max3(CLK_DIV, CS_SETUP, CS_IDLE));

  localparam logic [TMR_W-1:0] L_DIV   = TMR_W'(CLK_DIV - 1);
  localparam logic [TMR_W-1:0] L_SETUP = TMR_W'(CS_SETUP - 1);
  localparam logic [TMR_W-1:0] L_IDLE  = TMR_W'(CS_IDLE - 1);
  localparam logic [BIT_W-1:0] L_BITS  = BIT_W'(TOTAL_BITS - 1);

  spi_state_t              r_state;
  spi_state_t              w_state_nxt;
  logic [TOTAL_BITS-1:0]   r_shift;
  logic [BIT_W-1:0]        r_bits_left;
  logic                    r_cs;
  logic                    r_sck;
  logic                    r_mosi;
  logic                    r_busy;
  logic                    r_done;

  logic                    w_tmr_load;
  logic [TMR_W-1:0]        w_tmr_val;
  logic                    w_tmr_tc;
  logic                    w_accept;
  logic                    w_shift;
  logic                    w_cs_release;
  logic                    w_frame_end;
  logic                    w_sck_nxt;

  spi_phase_timer #(.W(TMR_W)) u_timer (
    .i_Clock    (i_Clock),
    .reset      (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_tc       (w_tmr_tc)
  );

  // Next-state decode; every phase change reloads the timer for the new phase.
  always_comb begin
    w_state_nxt  = r_state;
    w_tmr_load   = 1'b0;
    w_tmr_val    = '0;
    w_accept     = 1'b0;
    w_shift      = 1'b0;
    w_cs_release = 1'b0;
    w_frame_end  = 1'b0;
    w_sck_nxt    = r_sck;
    case (r_state)
      ST_IDLE: if (i_Start) begin
        w_accept    = 1'b1;
        w_tmr_load  = 1'b1;
        w_tmr_val   = L_SETUP;
        w_state_nxt = ST_SETUP;
      end
      ST_SETUP: if (w_tmr_tc) begin
        w_tmr_load  = 1'b1;
        w_tmr_val   = L_DIV;
        w_sck_nxt   = 1'b1;
        w_state_nxt = ST_HIGH;
      end
      ST_HIGH: if (w_tmr_tc) begin
        w_tmr_load = 1'b1;
        w_tmr_val  = L_DIV;
        w_sck_nxt  = 1'b0;
        if (r_bits_left == '0) begin
          w_state_nxt = ST_HOLD;
        end else begin
          w_shift     = 1'b1;
          w_state_nxt = ST_LOW;
        end
      end
      ST_LOW: if (w_tmr_tc) begin
        w_tmr_load  = 1'b1;
        w_tmr_val   = L_DIV;
        w_sck_nxt   = 1'b1;
        w_state_nxt = ST_HIGH;
      end
      ST_HOLD: if (w_tmr_tc) begin
        w_tmr_load   = 1'b1;
        w_tmr_val    = L_IDLE;
        w_cs_release = 1'b1;
        w_state_nxt  = ST_GAP;
      end
      ST_GAP: if (w_tmr_tc) begin
        w_frame_end = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, payload shifter and registered line drivers.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_bits_left <= '0;
      r_cs        <= 1'b1;
      r_sck       <= 1'b0;
      r_mosi      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sck   <= w_sck_nxt;
      r_done  <= w_frame_end;
      if (w_accept) begin
        r_shift     <= i_Data;
        r_bits_left <= L_BITS;
        r_mosi      <= i_Data[TOTAL_BITS-1];
        r_cs        <= 1'b0;
        r_busy      <= 1'b1;
      end
      if (w_shift) begin
        r_shift     <= r_shift << 1;
        r_bits_left <= r_bits_left - BIT_W'(1);
        r_mosi      <= r_shift[TOTAL_BITS-2];
      end
      if (w_cs_release) begin
        r_cs   <= 1'b1;
        r_mosi <= 1'b0;
      end
      if (w_frame_end) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_ADC_CS    = r_cs;
  assign o_ADC_Clock = r_sck;
  assign o_ADC_Data  = r_mosi;
  assign o_Busy      = r_busy;
  assign o_Done      = r_done;

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: a default-parameter instance and a minimal corner
// instance, each checked every cycle against a timing model plus literal checks.
module tb_adc_spi_master;

  localparam int A_D = 4, A_S = 2, A_I = 4, A_N = 64;
  localparam int C_D = 1, C_S = 1, C_I = 1, C_N = 16;
  localparam int A_BUSY = A_S + A_N * 2 * A_D + A_I;
  localparam int C_BUSY = C_S + C_N * 2 * C_D + C_I;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, start_a, busy_a, done_a, mosi_a, sck_a, cs_a;
  logic [63:0] data_a;
  logic        rst_c, start_c, busy_c, done_c, mosi_c, sck_c, cs_c;
  logic [15:0] data_c;

  adc_spi_master dut_a (
    .i_Clock(clk), .reset(rst_a), .i_Start(start_a), .i_Data(data_a),
    .o_Busy(busy_a), .o_Done(done_a), .o_ADC_Data(mosi_a),
    .o_ADC_Clock(sck_a), .o_ADC_CS(cs_a)
  );

  adc_spi_master #(.CLK_DIV(1), .WORD_BITS(16), .NUM_WORDS(1), .CS_SETUP(1), .CS_IDLE(1)) dut_c (
    .i_Clock(clk), .reset(rst_c), .i_Start(start_c), .i_Data(data_c),
    .o_Busy(busy_c), .o_Done(done_c), .o_ADC_Data(mosi_c),
    .o_ADC_Clock(sck_c), .o_ADC_CS(cs_c)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected {cs, sck, mosi, busy, done} t cycles after the accepting edge.
  function automatic logic [4:0] exp_out(input bit on, input int t, input int d, input int s,
                                         input int i, input int n, input logic [63:0] data);
    int  cslow, busyl, k;
    logic cs, sck, mosi, bsy, dn;
    if (!on) return 5'b10000;
    cslow = s + n * 2 * d;
    busyl = cslow + i;
    cs    = (t >= cslow);
    bsy   = (t < busyl);
    dn    = (t == busyl);
    sck   = (t >= s && t < cslow) ? (((t - s) / d) % 2 == 0) : 1'b0;
    if (t >= cslow) begin
      mosi = 1'b0;
    end else begin
      k = (t < s + d) ? 0 : (t - s - d) / (2 * d) + 1;
      if (k > n - 1) k = n - 1;
      mosi = data[n - 1 - k];
    end
    return {cs, sck, mosi, bsy, dn};
  endfunction

  // Frame models: decide acceptance from the start/reset rules and track cycle offset.
  bit ma_on = 0, mc_on = 0;
  int ma_t = 0, mc_t = 0;
  logic [63:0] ma_data = '0, mc_data = '0;

  always @(posedge clk) begin
    if (rst_a) ma_on = 0;
    else if ((!ma_on || ma_t == A_BUSY) && start_a) begin ma_on = 1; ma_t = 0; ma_data = data_a; end
    else if (ma_on && ma_t == A_BUSY) ma_on = 0;
    else if (ma_on) ma_t++;
    if (rst_c) mc_on = 0;
    else if ((!mc_on || mc_t == C_BUSY) && start_c) begin mc_on = 1; mc_t = 0; mc_data = {48'b0, data_c}; end
    else if (mc_on && mc_t == C_BUSY) mc_on = 0;
    else if (mc_on) mc_t++;
  end

  // Per-cycle comparison against the models.
  always @(negedge clk) begin
    chk("a_lines", {cs_a, sck_a, mosi_a, busy_a, done_a}, exp_out(ma_on, ma_t, A_D, A_S, A_I, A_N, ma_data));
    chk("c_lines", {cs_c, sck_c, mosi_c, busy_c, done_c}, exp_out(mc_on, mc_t, C_D, C_S, C_I, C_N, mc_data));
  end

  // Receiver-side measurements.
  int a_rises, a_cslow, a_dones = 0, a_last_done = -1;
  logic [63:0] a_cap;
  logic a_sck_p = 1'b0, a_cs_p = 1'b1;
  int a_done_q[$], a_csr_q[$], a_csf_q[$];

  int c_rises, c_cslow, c_dones = 0, c_last_done = -1, c_last_rise, c_spc_bad;
  logic [15:0] c_cap;
  logic c_sck_p = 1'b0;

  always @(negedge clk) begin
    if (sck_a && !a_sck_p) begin a_rises++; a_cap = {a_cap[62:0], mosi_a}; end
    if (!cs_a) a_cslow++;
    if (cs_a && !a_cs_p) a_csr_q.push_back(cyc);
    if (!cs_a && a_cs_p) a_csf_q.push_back(cyc);
    if (done_a) begin a_dones++; a_last_done = cyc; a_done_q.push_back(cyc); end
    a_sck_p = sck_a;
    a_cs_p  = cs_a;
    if (sck_c && !c_sck_p) begin
      if (c_rises > 0 && cyc - c_last_rise != 2) c_spc_bad++;
      c_rises++; c_last_rise = cyc; c_cap = {c_cap[14:0], mosi_c};
    end
    if (!cs_c) c_cslow++;
    if (done_c) begin c_dones++; c_last_done = cyc; end
    c_sck_p = sck_c;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_a();
    a_rises = 0; a_cslow = 0; a_cap = '0;
    a_done_q.delete(); a_csr_q.delete(); a_csf_q.delete();
  endtask

  task automatic wait_done(input bit use_c, input int target, input int limit, input string name);
    int k = 0;
    while ((use_c ? c_dones : a_dones) < target && k < limit) begin tick(); k++; end
    chk(name, use_c ? c_dones : a_dones, target);
  endtask

  int acc, d0, k;

  initial begin
    rst_a = 1; rst_c = 1; start_a = 0; start_c = 0; data_a = '0; data_c = '0;
    repeat (3) tick();
    chk("rst_cs", cs_a, 1); chk("rst_sck", sck_a, 0); chk("rst_mosi", mosi_a, 0);
    chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0);
    rst_a = 0; rst_c = 0;
    tick();

    // Single frame
    clear_a(); d0 = a_dones;
    data_a = 64'h1234_5678_9ABC_DEF0; start_a = 1; acc = cyc + 1; tick(); start_a = 0;
    wait_done(0, d0 + 1, 700, "single_done");
    chk("single_done_cyc", a_last_done - acc, 518);
    chk("single_rises", a_rises, 64);
    chk("single_cslow", a_cslow, 514);
    chk("single_w0", a_cap[63:48], 16'h1234);
    chk("single_w1", a_cap[47:32], 16'h5678);
    chk("single_w2", a_cap[31:16], 16'h9ABC);
    chk("single_w3", a_cap[15:0], 16'hDEF0);

    // Busy lockout
    tick(); clear_a(); d0 = a_dones;
    data_a = 64'hCAFE_F00D_0123_4567; start_a = 1; tick(); start_a = 0;
    repeat (9) tick();
    data_a = 64'hFFFF_0000_FFFF_0000; start_a = 1; tick(); start_a = 0;
    wait_done(0, d0 + 1, 700, "lock_done");
    repeat (600) tick();
    chk("lock_done_count", a_dones - d0, 1);
    chk("lock_payload", a_cap, 64'hCAFE_F00D_0123_4567);
    chk("lock_cslow", a_cslow, 514);

    // Back-to-back with start held
    tick(); clear_a(); d0 = a_dones;
    data_a = 64'h0800_0400_0000_FFFF; start_a = 1;
    wait_done(0, d0 + 2, 1200, "b2b_done2");
    tick(); start_a = 0;
    wait_done(0, d0 + 3, 700, "b2b_done3");
    chk("b2b_rises", a_rises, 192);
    chk("b2b_payload", a_cap, 64'h0800_0400_0000_FFFF);
    chk("b2b_done_n", a_done_q.size(), 3);
    if (a_done_q.size() == 3) begin
      chk("b2b_space1", a_done_q[1] - a_done_q[0], 519);
      chk("b2b_space2", a_done_q[2] - a_done_q[1], 519);
    end
    chk("b2b_cs_edges", a_csf_q.size() + a_csr_q.size(), 6);
    if (a_csf_q.size() == 3 && a_csr_q.size() == 3) begin
      chk("b2b_gap1", a_csf_q[1] - a_csr_q[0], 5);
      chk("b2b_gap2", a_csf_q[2] - a_csr_q[1], 5);
    end

    // Reset mid-frame
    tick(); clear_a(); d0 = a_dones;
    data_a = 64'hA5A5_5A5A_3C3C_C3C3; start_a = 1; tick(); start_a = 0;
    k = 0;
    while (a_rises < 20 && k < 1000) begin tick(); k++; end
    chk("mid_rise20", a_rises, 20);
    rst_a = 1; tick();
    chk("mid_cs", cs_a, 1); chk("mid_sck", sck_a, 0); chk("mid_mosi", mosi_a, 0);
    chk("mid_busy", busy_a, 0); chk("mid_done", done_a, 0);
    rst_a = 0;
    repeat (600) tick();
    chk("mid_no_done", a_dones - d0, 0);
    clear_a(); d0 = a_dones;
    data_a = 64'h1357_9BDF_2468_ACE0; start_a = 1; acc = cyc + 1; tick(); start_a = 0;
    wait_done(0, d0 + 1, 700, "fresh_done");
    chk("fresh_done_cyc", a_last_done - acc, 518);
    chk("fresh_rises", a_rises, 64);
    chk("fresh_payload", a_cap, 64'h1357_9BDF_2468_ACE0);

    // Parameter corner
    tick();
    c_rises = 0; c_cslow = 0; c_cap = '0; c_spc_bad = 0; c_last_rise = 0; d0 = c_dones;
    data_c = 16'h8001; start_c = 1; acc = cyc + 1; tick(); start_c = 0;
    wait_done(1, d0 + 1, 100, "corner_done");
    chk("corner_done_cyc", c_last_done - acc, 34);
    chk("corner_rises", c_rises, 16);
    chk("corner_cslow", c_cslow, 33);
    chk("corner_period", c_spc_bad, 0);
    chk("corner_payload", c_cap, 16'h8001);

    repeat (5) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "timeout");
  end

endmodule
